// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: ImmSrc codes, RV32I opcodes and the S1 payload shared by the encoder
package imm_encoder_pkg;
  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  typedef struct packed {
    logic [2:0]  src;
    logic [31:7] imm_bits;
    logic        fits;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
  } s1_t;
endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: range-checks an immediate and scatters it into instruction bits [31:7]
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  output logic [31:7] imm_bits,
  output logic        fits
);
  logic [31:7] raw;
  logic i_ok, b_ok, j_ok, u_ok;
  always_comb begin
    i_ok = &imm[31:11] | ~|imm[31:11];
    b_ok = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
    j_ok = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
    u_ok = ~|imm[11:0];
    fits = 1'b1;
    raw  = '0;
    case (imm_src)
      IMM_I: begin fits = i_ok; raw = {imm[11:0], 13'b0}; end
      IMM_S: begin fits = i_ok; raw = {imm[11:5], 13'b0, imm[4:0]}; end
      IMM_B: begin fits = b_ok; raw = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11]}; end
      IMM_U: begin fits = u_ok; raw = {imm[31:12], 5'b0}; end
      IMM_J: begin fits = j_ok; raw = {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0}; end
      default: ;
    endcase
    imm_bits = fits ? raw : '0;
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline assembling RV32I words from immediate and fields
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] Imm,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  enc_count,
  output logic [CNT_WIDTH-1:0]  err_count
);
  s1_t s1_d, s1_q;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic [DATA_WIDTH-1:0] instr_d, instr_q;
  logic err_d, err_q, s2_adv, s2_load, in_fire, out_fire, fits;
  logic [CNT_WIDTH-1:0] enc_d, enc_q, errc_d, errc_q;
  logic [31:7] imm_bits, fld;
  imm_pack u_pack (.imm(Imm), .imm_src(ImmSrc), .imm_bits(imm_bits), .fits(fits));
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !rst && (!s1_valid_q || s2_adv);
    in_fire    = in_valid && in_ready;
    out_fire   = s2_valid_q && out_ready;
    s2_load    = s2_adv && s1_valid_q;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d       = in_fire ? {ImmSrc, imm_bits, fits, funct7, rs2, rs1, rd, funct3, opcode} : s1_q;
    case (s1_q.src)
      IMM_I:        fld = {12'b0, s1_q.rs1, s1_q.funct3, s1_q.rd};
      IMM_S, IMM_B: fld = {7'b0, s1_q.rs2, s1_q.rs1, s1_q.funct3, 5'b0};
      IMM_U, IMM_J: fld = {20'b0, s1_q.rd};
      default:      fld = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd};
    endcase
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    instr_d    = s2_load ? {fld | s1_q.imm_bits, s1_q.opcode} : instr_q;
    err_d      = s2_load ? !s1_q.fits : err_q;
    enc_d      = enc_q + CNT_WIDTH'(in_fire && ~&enc_q);
    errc_d     = errc_q + CNT_WIDTH'(out_fire && err_q && ~&errc_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      enc_q      <= '0;
      errc_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      enc_q      <= enc_d;
      errc_q     <= errc_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign Instr     = instr_q;
  assign out_err   = err_q;
  assign enc_count = enc_q;
  assign err_count = errc_q;
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender. Takes a 32-bit immediate, register/function fields and an ImmSrc format code.
- Range-checks the immediate, scatters it into instruction bits [31:7] and assembles a full 32-bit RV32I instruction word.
- Used by the self-test instruction generator and the boot-image patcher ahead of instruction memory.
- Two-stage valid/ready pipeline with full backpressure and error/throughput counters.

Parameters:
- DATA_WIDTH, 32, immediate and instruction width; only 32 is supported.
- CNT_WIDTH, 16, width of the encoded and error counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- ImmSrc  input  3  format code: 001 I, 010 S, 011 B, 100 U, 101 J; other values are R (immediate ignored)
- Imm  input  DATA_WIDTH  signed immediate byte value (B/J offsets are byte offsets)
- opcode  input  7  opcode
- rd, rs1, rs2  input  5 each  register fields
- funct3  input  3  funct3
- funct7  input  7  funct7 (R only)
- out_valid  output  1  instruction valid
- out_ready  input  1  consumer ready
- Instr  output  DATA_WIDTH  assembled instruction
- out_err  output  1  immediate not representable; qualified by out_valid
- enc_count  output  CNT_WIDTH  accepted requests, saturating
- err_count  output  CNT_WIDTH  requests with out_err=1, saturating

Behaviour:
- Reset (synchronous, active-high): out_valid=0, Instr=0, out_err=0, enc_count=0, err_count=0; both stage valids cleared and in-flight items discarded. in_ready=1 from the first cycle after reset deasserts; in_ready=0 while rst=1.
- Latency: exactly 2 cycles from acceptance to out_valid when out_ready=1. Throughput: 1 instruction per cycle.
- Stage S1 registers the fields plus the result of the range check.
- Stage S2 registers Instr and out_err.
- Handshake:
  - in_ready = !s1_valid || s1 advances; s1 advances when !s2_valid || out_ready (combinational stall chain, no bubbles).
  - Instr and out_err hold stable while out_valid && !out_ready.
  - in_valid may drop without being accepted.
- Range checks:
  - I/S: Imm[31:11] all equal.
  - B: Imm[31:12] all equal and Imm[0]=0.
  - J: Imm[31:20] all equal and Imm[0]=0.
  - U: Imm[11:0]=0.
  - R: always passes.
- Immediate scatter into Instr:
  - I: [31:20]=Imm[11:0].
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0].
  - B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11].
  - U: [31:12]=Imm[31:12].
  - J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
- Non-immediate fields:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: rs1, funct3, rd, opcode.
  - S/B: rs2, rs1, funct3, opcode.
  - U/J: rd, opcode.
  - Instr[6:0]=opcode always.
- On range failure: all immediate bit positions are driven 0, other fields are encoded normally, out_err=1.
- Round-trip invariant: for out_err=0 and ImmSrc 001..101, sign-extending Instr[31:7] with the same ImmSrc reproduces Imm exactly.
- Counters:
  - enc_count increments on each input handshake.
  - err_count increments on each output handshake with out_err=1.
  - Both saturate at all-ones with no wrap.
- Simultaneous in-handshake and out-handshake in a full pipe: both occur; occupancy is unchanged.

Decomposition:
- Shared package holds:
  - ImmSrc constants: IMM_I=3'b001, IMM_S=3'b010, IMM_B=3'b011, IMM_U=3'b100, IMM_J=3'b101, IMM_R=3'b000.
  - RV32I opcode localparams.
  - A packed struct for the S1 payload.
- One combinational sub-module, imm_pack: (Imm, ImmSrc) -> (imm_bits[31:7], fits). It is instantiated before S1.

Test Plan:
- I-type: ImmSrc=001, Imm=-1, rd=1, rs1=2, funct3=0, opcode=0x13 -> Instr=0xFFF10093 after 2 cycles, out_err=0.
- B-type: ImmSrc=011, Imm=-4, rs1=1, rs2=2, funct3=1, opcode=0x63 -> Instr=0xFE209EE3. Same request with Imm=4097 (odd) -> out_err=1, immediate bits 0, err_count=1.
- U/J boundaries:
  - U with Imm=0x12345000 -> Instr[31:12]=0x12345.
  - J with Imm=1048574 -> out_err=0.
  - J with Imm=1048576 -> out_err=1.
- Backpressure: stream 5 requests with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, Instr holds stable. Release -> all 5 emerge in order, enc_count=5.
- Reset mid-stream: assert rst with 2 items in flight -> next cycle out_valid=0 and counters=0; the items never appear.
- Random round-trip: 10k random requests with random stalls -> every out_err=0 output sign-extends back to Imm; error prediction matches the model; counters saturate when forced to all-ones.
